// File: rtl/time_bin_sequencer.sv
`default_nettype none
// ============================================================================
// time_bin_sequencer : per-bin clear/gate/settle/capture run controller with a
// first-word-fall-through capture FIFO.                              Rev 1.0
// ============================================================================

module time_bin_sequencer #(
  parameter int CNT_W      = 8,
  parameter int LEN_W      = 20,
  parameter int NBIN_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_LAT    = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  bin_len_i,
  input  logic [NBIN_W-1:0] num_bins_i,
  input  logic [CNT_W-1:0]  cnt_in_i,
  output logic              cnt_clr_o,
  output logic              gate_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [NBIN_W-1:0] bin_idx_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i
);

  localparam int               PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LEN_W-1:0] LAT_M1 = LEN_W'(CNT_LAT - 1);
  localparam logic [PTR_W:0]   DEPTH  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_COUNT   = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  timer_q, timer_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NBIN_W-1:0] nbins_q, nbins_d;
  logic [NBIN_W-1:0] bin_idx_q, bin_idx_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              cnt_clr_q, gate_q, busy_q;

  logic              cap_req, wr_en, rd_fire, full, not_empty;

  logic [CNT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == DEPTH);
  assign rd_fire   = not_empty && rd_ready_i;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    len_d      = len_q;
    nbins_d    = nbins_q;
    bin_idx_d  = bin_idx_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    cap_req    = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          len_d      = bin_len_i;
          nbins_d    = num_bins_i;
          overflow_d = 1'b0;
          bin_idx_d  = '0;
          if (num_bins_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_CLEAR;
            timer_d = LAT_M1;
          end
        end
      end
      S_CLEAR: begin
        if (timer_q == '0) begin
          state_d = S_COUNT;
          // A zero length still opens the gate for one clock.
          timer_d = (len_q == '0) ? '0 : len_q - LEN_W'(1);
        end else begin
          timer_d = timer_q - LEN_W'(1);
        end
      end
      S_COUNT: begin
        if (timer_q == '0) begin
          state_d = S_SETTLE;
          timer_d = LAT_M1;
        end else begin
          timer_d = timer_q - LEN_W'(1);
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          timer_d = timer_q - LEN_W'(1);
        end
      end
      S_CAPTURE: begin
        cap_req = 1'b1;
        if (bin_idx_q == nbins_q - NBIN_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          bin_idx_d = bin_idx_q + NBIN_W'(1);
          state_d   = S_CLEAR;
          timer_d   = LAT_M1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      cap_req = 1'b0;
    end

    // A full FIFO still accepts the sample when a read frees a slot this cycle.
    wr_en = cap_req && (!full || rd_fire);
    if (cap_req && !wr_en) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      len_q      <= '0;
      nbins_q    <= '0;
      bin_idx_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_clr_q  <= 1'b0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      len_q      <= len_d;
      nbins_q    <= nbins_d;
      bin_idx_q  <= bin_idx_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      cnt_clr_q  <= (state_d == S_CLEAR);
      gate_q     <= (state_d == S_COUNT);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(rd_fire);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= cnt_in_i;
    end
  end

  assign cnt_clr_o  = cnt_clr_q;
  assign gate_o     = gate_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign bin_idx_o  = bin_idx_q;
  assign overflow_o = overflow_q;
  assign rd_valid_o = not_empty;
  assign rd_data_o  = not_empty ? mem_q[rd_ptr_q] : '0;

endmodule

`default_nettype wire

// File: doc/time_bin_sequencer.md
# time_bin_sequencer

Run-level controller for the photon-count time-bin counter. On a start command it steps through a programmed number of consecutive time bins. For each bin it clears the counter, opens a counting gate for a programmed number of clocks, waits out the counter's pipeline latency, and captures the count into an internal FIFO. Host-side logic drains the FIFO over a valid/ready port. The block sits between the PMT counter and the readout/communication logic.

## Interface
- CNT_W, 8, width of counter value
- LEN_W, 20, width of bin length in clocks (5 ms at 50 MHz = 250000 fits)
- NBIN_W, 8, width of bin count
- FIFO_DEPTH, 16, capture FIFO entries (power of two)
- CNT_LAT, 2, counter pipeline latency in clocks (clear-to-zero and edge-to-increment)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a run when idle
- abort  in  1  level/pulse; terminates a run
- bin_len  in  LEN_W  gate length in clocks, sampled at start
- num_bins  in  NBIN_W  bins per run, sampled at start
- cnt_in  in  CNT_W  counter output value
- cnt_clr  out  1  counter clear (drives counter reset input)
- gate  out  1  high while a bin is counting
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse when a run completes normally
- bin_idx  out  NBIN_W  index of current bin, 0-based
- overflow  out  1  sticky: a capture was dropped because FIFO full
- rd_data  out  CNT_W  FIFO head
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts rd_data when rd_valid && rd_ready

## Operation
- States: IDLE, CLEAR, COUNT, SETTLE, CAPTURE.
- IDLE: busy=0, gate=0, cnt_clr=0.
  - start=1 latches bin_len and num_bins, clears overflow, and sets bin_idx=0.
  - If num_bins=0: done pulses next cycle and the block stays in IDLE.
  - Otherwise it moves to CLEAR.
- CLEAR: cnt_clr=1 for exactly CNT_LAT cycles, then COUNT.
- COUNT: gate=1 for exactly max(bin_len,1) cycles; bin_len=0 behaves as 1. Then SETTLE.
- SETTLE: gate=0, cnt_clr=0, for CNT_LAT cycles, then CAPTURE.
- CAPTURE: one cycle; writes cnt_in into the FIFO.
  - If bin_idx=num_bins−1: next state is IDLE with done=1 on that transition.
  - Otherwise: bin_idx increments and the next state is CLEAR.
- FIFO full at CAPTURE: the sample is dropped and overflow is set.
  - Exception: if a read handshake occurs in the same cycle, the write is accepted and overflow is not set.
- start while busy: ignored; latched parameters are unchanged.
- abort while busy: next state IDLE, gate and cnt_clr deassert next cycle, no done pulse. FIFO contents are retained. abort in IDLE has no effect; abort has priority over start.
- FIFO is first-word-fall-through. Reads are allowed in any state, concurrent with writes.
- Counter values are passed through unmodified; no arithmetic on CNT_W data.

## Timing
- Reset values:
  - state=IDLE, FIFO empty
  - cnt_clr=0, gate=0, busy=0, done=0, bin_idx=0, overflow=0, rd_valid=0
  - rd_data=0
- Latency from start to the first cnt_clr high is 1 clock (registered outputs).
- Per-bin period = CNT_LAT + max(bin_len,1) + CNT_LAT + 1 clocks. Dead time between gates = 2·CNT_LAT+1.
- rd_valid rises 1 clock after the CAPTURE edge that writes into an empty FIFO.
- Reset mid-run: immediate return to reset values, including FIFO flush; outputs are not glitched beyond the async clear.

## Test plan
- Basic run: bin_len=10, num_bins=3, CNT_LAT=2, cnt_in driven by a model counter fed a 1-per-4-clock pulse train.
  - Expect gate high 10 clocks per bin and period 15 clocks.
  - Expect 3 FIFO entries matching the model counts, and done once after the third CAPTURE.
- Boundary lengths:
  - num_bins=0: done 1 clock after start, no gate, no FIFO writes.
  - bin_len=0: gate high exactly 1 clock per bin.
- Overflow: rd_ready=0, num_bins=20, FIFO_DEPTH=16. Expect 16 entries, overflow=1 from the 17th CAPTURE, and entries 0–15 intact in order. The next start clears overflow.
- Full plus simultaneous read: FIFO full and rd_ready=1 on a CAPTURE cycle. Expect the write accepted, overflow=0, occupancy unchanged.
- Abort and start-while-busy:
  - start during COUNT is ignored.
  - abort during COUNT of bin 1: next cycle gate=0, busy=0, no done; FIFO holds 1 entry.
- Async reset mid-SETTLE: all outputs at reset values before the next clock edge, FIFO empty, and a new start runs normally.
